// File: rtl/opti_bypass.sv
// Execute-stage operand bypass/select: forwards the ALU result onto rs1/rs2,
// picks the ALU operands, supplies store data and branch compare flags.
// Optional macro OPTI_CMP_REG_EN registers Breq/Brlt (one cycle of latency).
module opti_bypass #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            A1_sel,
   input  logic            B1_sel,
   input  logic            A2_sel,
   input  logic            B2_sel,
   input  logic            Brun,
   input  logic [XLEN-1:0] reg_rs1,
   input  logic [XLEN-1:0] reg_rs2,
   input  logic [XLEN-1:0] alu,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   output logic            Breq,
   output logic            Brlt,
   output logic [XLEN-1:0] reg1,
   output logic [XLEN-1:0] reg2,
   output logic [XLEN-1:0] data_w
);

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic            breq_d;
   logic            brlt_d;

   // Per-bit two-way selects; a known select never lets the unused leg through.
   for (genvar gi = 0; gi < XLEN; gi++) begin : g_mux
      assign fwd_rs1[gi] = A1_sel ? alu[gi]     : reg_rs1[gi];
      assign fwd_rs2[gi] = B1_sel ? alu[gi]     : reg_rs2[gi];
      assign reg1[gi]    = A2_sel ? pc[gi]      : fwd_rs1[gi];
      assign reg2[gi]    = B2_sel ? imm[gi]     : fwd_rs2[gi];
   end

   // Store data is always the forwarded rs2, independent of the operand-B select.
   assign data_w = fwd_rs2;

   always_comb begin
      breq_d = (fwd_rs1 == fwd_rs2);
      brlt_d = 1'b0;
      if (Brun) begin
         brlt_d = (fwd_rs1 < fwd_rs2);
      end else begin
         brlt_d = ($signed(fwd_rs1) < $signed(fwd_rs2));
      end
   end

`ifdef OPTI_CMP_REG_EN
   logic breq_q;
   logic brlt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         breq_q <= 1'b0;
         brlt_q <= 1'b0;
      end else begin
         breq_q <= breq_d;
         brlt_q <= brlt_d;
      end
   end

   assign Breq = breq_q;
   assign Brlt = brlt_q;
`else
   // Purely combinational build: clock and reset are intentionally unused.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   assign Breq = breq_d;
   assign Brlt = brlt_d;
`endif

endmodule

// File: tb/tb_opti_bypass.sv
// Scoreboard bench for opti_bypass: driver pushes model results, monitor pops
// and compares on every falling edge. Handles both OPTI_CMP_REG_EN builds.
module tb_opti_bypass;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            A1_sel = 1'b0, B1_sel = 1'b0, A2_sel = 1'b0, B2_sel = 1'b0, Brun = 1'b0;
   logic [XLEN-1:0] reg_rs1 = '0, reg_rs2 = '0, alu = '0, pc = '0, imm = '0;
   logic            Breq, Brlt;
   logic [XLEN-1:0] reg1, reg2, data_w;

   opti_bypass #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .A1_sel(A1_sel), .B1_sel(B1_sel), .A2_sel(A2_sel), .B2_sel(B2_sel), .Brun(Brun),
      .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .alu(alu), .pc(pc), .imm(imm),
      .Breq(Breq), .Brlt(Brlt), .reg1(reg1), .reg2(reg2), .data_w(data_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [XLEN-1:0] r1;
      logic [XLEN-1:0] r2;
      logic [XLEN-1:0] dw;
      logic            eq;
      logic            lt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Flags the registered build will show on the next transaction.
   logic prev_eq = 1'b0;
   logic prev_lt = 1'b0;

   task automatic check(input string nm, input string fld,
                        input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, req);
   endtask

   // Reference model: operand and compare results straight from the rules.
   task automatic drive(input string nm, input logic rst_v, input logic [4:0] sel,
                        input logic [XLEN-1:0] rs1_v, input logic [XLEN-1:0] rs2_v,
                        input logic [XLEN-1:0] alu_v, input logic [XLEN-1:0] pc_v,
                        input logic [XLEN-1:0] imm_v);
      exp_t            e;
      logic [XLEN-1:0] src_a, src_b;
      logic            eq_now, lt_now;
      @(posedge clk);
      #1;
      rst = rst_v;
      {A1_sel, B1_sel, A2_sel, B2_sel, Brun} = sel;
      reg_rs1 = rs1_v; reg_rs2 = rs2_v; alu = alu_v; pc = pc_v; imm = imm_v;
      src_a = sel[4] ? alu_v : rs1_v;
      src_b = sel[3] ? alu_v : rs2_v;
      eq_now = (src_a == src_b);
      if (sel[0]) lt_now = (longint'({32'h0, src_a}) < longint'({32'h0, src_b}));
      else        lt_now = (int'(src_a) < int'(src_b));
      e.name = nm;
      e.r1 = sel[2] ? pc_v : src_a;
      e.r2 = sel[1] ? imm_v : src_b;
      e.dw = src_b;
`ifdef OPTI_CMP_REG_EN
      e.eq = prev_eq;
      e.lt = prev_lt;
      prev_eq = rst_v ? 1'b0 : eq_now;
      prev_lt = rst_v ? 1'b0 : lt_now;
`else
      e.eq = eq_now;
      e.lt = lt_now;
`endif
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.name, "reg1",   reg1,   e.r1);
         check(e.name, "reg2",   reg2,   e.r2);
         check(e.name, "data_w", data_w, e.dw);
         check(e.name, "Breq",   {31'h0, Breq}, {31'h0, e.eq});
         check(e.name, "Brlt",   {31'h0, Brlt}, {31'h0, e.lt});
         $display("txn %-8s rst=%0b sel=%b reg1=%08h reg2=%08h data_w=%08h Breq=%0b Brlt=%0b",
                  e.name, rst, {A1_sel, B1_sel, A2_sel, B2_sel, Brun},
                  reg1, reg2, data_w, Breq, Brlt);
      end
   end

   initial begin
      logic [XLEN-1:0] a, b, c;
      logic [XLEN-1:0] corner [4];
      int              budget;
      corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF;
      corner[2] = 32'h0000_0000; corner[3] = 32'hFFFF_FFFF;

      // Reset phase (sel order: A1 B1 A2 B2 Brun).
      drive("rst0", 1'b1, 5'b00000, 32'h5, 32'h9, 32'h1, 32'h2, 32'h3);
      drive("rst1", 1'b1, 5'b00001, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0);
      drive("t1", 1'b0, 5'b00000, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
      drive("t2", 1'b0, 5'b11000, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
      drive("t3", 1'b0, 5'b11110, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
      drive("t4s", 1'b0, 5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 32'h0);
      drive("t4u", 1'b0, 5'b00001, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 32'h0);
      drive("t5b1", 1'b0, 5'b01000, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 32'h0);
      drive("t5b0", 1'b0, 5'b00000, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 32'h0);
      drive("rstmid", 1'b1, 5'b00001, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
      drive("post", 1'b0, 5'b00000, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h0);

      for (int i = 0; i < 300; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         case ($urandom_range(0, 3))
            0: b = a;
            1: c = a;
            2: begin a = corner[$urandom_range(0, 3)]; b = corner[$urandom_range(0, 3)]; end
            default: ;
         endcase
         drive("rand", ($urandom_range(0, 19) == 0), 5'($urandom), a, b, c, $urandom, $urandom);
      end

      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(posedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d required=0 pending", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
